fft_frame_ctrl: RTL

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

---
 rtl/fft_frame_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: sequences one 32-point FFT frame through load, pipeline
// drain, sorter capture and 64-word answer streaming, with abort (flush),
// seq-timeout error handling and a wrapping completed-frame counter.
module fft_frame_ctrl #(
  parameter int PIPE_LAT    = 31,
  parameter int SEQ_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  input  logic       seq,
  output logic       pipe_en,
  output logic       start_sorting,
  output logic       out_valid,
  output logic [5:0] out_idx,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] frame_cnt
);

  // One shared cycle counter serves DRAIN, SORT and the STREAM timeout,
  // so it is sized for the largest of the three spans.
  localparam int MAX_A = (PIPE_LAT > SEQ_TIMEOUT) ? PIPE_LAT : SEQ_TIMEOUT;
  localparam int MAX_C = (MAX_A > 32) ? MAX_A : 32;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] DRAIN_END = CW'(PIPE_LAT - 1);
  localparam logic [CW-1:0] SORT_END  = CW'(31);
  localparam logic [CW-1:0] TMO_END   = CW'(SEQ_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DRAIN  = 3'd2,
    SORT   = 3'd3,
    STREAM = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  state_t        state_reg;
  logic [4:0]    samp_cnt_reg;
  logic [CW-1:0] cyc_cnt_reg;
  logic [6:0]    word_cnt_reg;
  logic          out_valid_reg;
  logic [5:0]    out_idx_reg;
  logic          out_last_reg;
  logic          err_reg;
  logic [7:0]    frame_cnt_reg;

  logic xfer;
  logic take_word;

  // Handshake and enables decode straight from the state register; a sample
  // presented together with flush (or during reset) never advances the datapath.
  assign in_ready      = (state_reg == IDLE) || (state_reg == LOAD);
  assign xfer          = rst_n & in_valid & in_ready & ~flush;
  assign pipe_en       = xfer || (state_reg == DRAIN) || (state_reg == SORT);
  assign start_sorting = (state_reg == SORT);
  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == DONE);

  // A sorter word is accepted only in STREAM and only until all 64 have arrived.
  assign take_word = (state_reg == STREAM) && seq && !word_cnt_reg[6];

  assign out_valid = out_valid_reg;
  assign out_idx   = out_idx_reg;
  assign out_last  = out_last_reg;
  assign err       = err_reg;
  assign frame_cnt = frame_cnt_reg;

  // Frame sequencer: state, phase counters and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      samp_cnt_reg  <= '0;
      cyc_cnt_reg   <= '0;
      word_cnt_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_idx_reg   <= '0;
      out_last_reg  <= 1'b0;
      err_reg       <= 1'b0;
      frame_cnt_reg <= '0;
    end else if (flush) begin
      state_reg     <= IDLE;
      samp_cnt_reg  <= '0;
      cyc_cnt_reg   <= '0;
      word_cnt_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_idx_reg   <= '0;
      out_last_reg  <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      out_valid_reg <= take_word;
      out_last_reg  <= take_word && (word_cnt_reg == 7'd63);
      if (take_word) begin
        out_idx_reg  <= word_cnt_reg[5:0];
        word_cnt_reg <= word_cnt_reg + 7'd1;
      end

      case (state_reg)
        IDLE: begin
          if (xfer) begin
            state_reg    <= LOAD;
            samp_cnt_reg <= 5'd1;
          end
        end
        LOAD: begin
          if (xfer) begin
            samp_cnt_reg <= samp_cnt_reg + 5'd1;
            if (samp_cnt_reg == 5'd31) begin
              state_reg   <= DRAIN;
              cyc_cnt_reg <= '0;
            end
          end
        end
        DRAIN: begin
          if (cyc_cnt_reg == DRAIN_END) begin
            state_reg   <= SORT;
            cyc_cnt_reg <= '0;
          end else begin
            cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
          end
        end
        SORT: begin
          if (cyc_cnt_reg == SORT_END) begin
            state_reg    <= STREAM;
            cyc_cnt_reg  <= '0;
            word_cnt_reg <= '0;
          end else begin
            cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
          end
        end
        STREAM: begin
          // The last word has been presented; close the frame next.
          if (word_cnt_reg[6]) begin
            state_reg     <= DONE;
            word_cnt_reg  <= '0;
            frame_cnt_reg <= frame_cnt_reg + 8'd1;
          end else if ((word_cnt_reg == 7'd0) && !seq) begin
            // Sorter never started streaming: give up after the timeout.
            if (cyc_cnt_reg == TMO_END) begin
              state_reg <= ERR;
              err_reg   <= 1'b1;
            end else begin
              cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        ERR: begin
          state_reg <= ERR;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
